// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch-stage PC select, next-PC prediction and decode register
// Optional INSTR_CHECK_EN: halt with stat=INS on icode > 0xB instead of treating it as a NOP.
module fetch_pc_unit #(
    parameter int                 PC_WID     = 32,
    parameter logic [PC_WID-1:0]  RESET_PC   = '0,
    parameter int                 VALC_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_WID-1:0] PC,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [PC_WID-1:0] valC,
    input  logic              F_stall,
    input  logic              D_stall,
    input  logic              D_bubble,
    input  logic              M_mispredict,
    input  logic [PC_WID-1:0] M_valA,
    input  logic              W_ret,
    input  logic [PC_WID-1:0] W_valM,
    output logic [3:0]        D_icode,
    output logic [3:0]        D_ifun,
    output logic [3:0]        D_rA,
    output logic [3:0]        D_rB,
    output logic [PC_WID-1:0] D_valC,
    output logic [PC_WID-1:0] D_valP,
    output logic              D_valid,
    output logic [1:0]        stat
);
    typedef enum logic {S_RUN, S_HALT} state_t;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_INS = 2'd2;

    state_t            state_q;
    logic [PC_WID-1:0] pred_pc_q;

    logic              redirect;
    logic [PC_WID-1:0] redirect_pc;
    logic              need_regids;
    logic              need_valc;
    logic [PC_WID-1:0] val_p;
    logic [PC_WID-1:0] pred_next;
    logic              fetch_go;
    logic              stop_hlt;
    logic              stop_ins;

    assign redirect    = M_mispredict | W_ret;
    assign redirect_pc = M_mispredict ? M_valA : W_valM;
    assign PC          = redirect ? redirect_pc : pred_pc_q;

    always_comb begin
        need_regids = 1'b0;
        need_valc   = 1'b0;
        case (icode)
            4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
            4'h3, 4'h4, 4'h5: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            4'h7, 4'h8: need_valc = 1'b1;
            default: ;
        endcase
    end

    assign val_p = PC + PC_WID'(1) + PC_WID'(need_regids)
                 + (need_valc ? PC_WID'(VALC_BYTES) : '0);
    assign pred_next = (icode == 4'h7 || icode == 4'h8) ? valC : val_p;

    // A fetch only commits (and may halt) when it actually enters decode and fetch is not stalled.
    assign fetch_go = (state_q == S_RUN) && !F_stall && !D_stall && !D_bubble;
    assign stop_hlt = fetch_go && (icode == 4'h0);
`ifdef INSTR_CHECK_EN
    assign stop_ins = fetch_go && (icode > 4'hB);
`else
    assign stop_ins = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            pred_pc_q <= RESET_PC;
            stat      <= STAT_AOK;
            D_icode   <= 4'h1;
            D_ifun    <= 4'h0;
            D_rA      <= 4'h0;
            D_rB      <= 4'h0;
            D_valC    <= '0;
            D_valP    <= '0;
            D_valid   <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (stop_hlt || stop_ins) begin
                        pred_pc_q <= PC;
                        state_q   <= S_HALT;
                        stat      <= stop_ins ? STAT_INS : STAT_HLT;
                    end else if (!F_stall) begin
                        pred_pc_q <= pred_next;
                    end else if (redirect) begin
                        pred_pc_q <= redirect_pc;
                    end
                end
                S_HALT: begin
                    if (redirect) begin
                        pred_pc_q <= redirect_pc;
                        state_q   <= S_RUN;
                        stat      <= STAT_AOK;
                    end
                end
                default: state_q <= S_RUN;
            endcase

            if (D_bubble || (state_q == S_HALT && !D_stall)) begin
                D_icode <= 4'h1;
                D_ifun  <= 4'h0;
                D_rA    <= 4'h0;
                D_rB    <= 4'h0;
                D_valC  <= '0;
                D_valP  <= '0;
                D_valid <= 1'b0;
            end else if (!D_stall) begin
                D_icode <= icode;
                D_ifun  <= ifun;
                D_rA    <= rA;
                D_rB    <= rB;
                D_valC  <= valC;
                D_valP  <= val_p;
                D_valid <= 1'b1;
            end
        end
    end
endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter PC_WID, default 32, width of PC, valC, valP and redirect targets.
REQ-002 Parameter RESET_PC, default 0, fetch address after reset.
REQ-003 Parameter VALC_BYTES, default 4, byte length of the constant field.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 PC  out  PC_WID  fetch address to instruction memory.
REQ-007 icode, ifun, rA, rB  in  4 each  instruction fields returned by instruction memory for PC.
REQ-008 valC  in  PC_WID  constant field returned by instruction memory.
REQ-009 F_stall  in  1  hold fetch PC.
REQ-010 D_stall  in  1  hold decode register.
REQ-011 D_bubble  in  1  load NOP into decode register.
REQ-012 M_mispredict  in  1  not-taken jump resolved in M stage.
REQ-013 M_valA  in  PC_WID  fall-through address for mispredict.
REQ-014 W_ret  in  1  return completing in W stage.
REQ-015 W_valM  in  PC_WID  return address.
REQ-016 D_icode, D_ifun, D_rA, D_rB  out  4 each  registered fields to decode.
REQ-017 D_valC, D_valP  out  PC_WID  registered constant and next-sequential PC.
REQ-018 D_valid  out  1  decode register holds a real instruction.
REQ-019 stat  out  2  0=AOK, 1=HLT, 2=INS.

Function
REQ-020 PC is combinational: M_mispredict ? M_valA : W_ret ? W_valM : predPC register.
REQ-021 need_regids = icode in {2,3,4,5,6,A,B}; need_valC = icode in {3,4,5,7,8}.
REQ-022 valP = PC + 1 + need_regids + VALC_BYTES*need_valC, modulo 2^PC_WID (wrap, no flag).
REQ-023 Predicted next PC = valC when icode is 7 (jXX) or 8 (call), else valP.
REQ-024 predPC loads the prediction each cycle when F_stall=0 and state is RUN.
REQ-025 When F_stall=1 and a redirect (M_mispredict or W_ret) is active in the same cycle, predPC loads the selected redirect target so it is not lost; otherwise F_stall=1 holds predPC.
REQ-026 Decode register priority: D_bubble (icode=1, others 0, D_valid=0) > D_stall (hold) > load fetched fields, valC, valP, D_valid=1.
REQ-027 Fetch-to-decode latency one cycle.
REQ-028 States RUN and HALT; RUN->HALT on a loaded fetch with icode=0 (halt enters decode with D_valid=1); stat=HLT while in HALT.
REQ-029 In HALT: predPC held, decode register loads bubbles unless D_stall; HALT->RUN when M_mispredict or W_ret, predPC loads redirect target, stat returns to AOK.
REQ-030 Fetch with F_stall=1 never causes a state transition.

Reset
REQ-031 rst_n=0 immediately sets predPC=RESET_PC, state RUN, stat=AOK, D_icode=1, D_valid=0, all other D_* outputs 0.
REQ-032 Reset mid-operation discards any pending redirect, halt or stall; first fetch after release is at RESET_PC.

Configuration
REQ-033 Macro INSTR_CHECK_EN defined: icode > 0xB treated as invalid, state enters HALT with stat=INS, recoverable only as in REQ-029.
REQ-034 INSTR_CHECK_EN undefined: icode > 0xB treated as 1-byte NOP, stat never reports INS.

Verification
REQ-035 Reset, icode=1 at PC 0 -> PC=0, next cycle PC=1, D_icode=1, D_valP=1, D_valid=1.
REQ-036 PC=0x10, icode=3 -> D_valP=0x16; icode=7 with valC=0x40 -> next PC=0x40.
REQ-037 F_stall=1 two cycles with PC=0x20 -> PC stays 0x20; D_bubble=1 -> D_valid=0, D_icode=1.
REQ-038 M_mispredict=1, M_valA=0x30 with W_ret=1, W_valM=0x50, F_stall=1 -> PC=0x30, next cycle PC=0x30.
REQ-039 icode=0 fetched -> stat=HLT next cycle, PC held, D_valid=0 after halt; then W_ret=1, W_valM=0x80 -> PC=0x80, stat=AOK.
REQ-040 With INSTR_CHECK_EN, icode=0xE -> stat=INS and PC held; without it, D_valP=PC+1 and stat=AOK.
